// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and address helper for the
// pixel-plot framebuffer and its VGA scan-out.
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int COLOUR_W = 3;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0] data;
  } fb_wr_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // row*320 built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] col, input logic [8:0] row);
    return {row, 8'h00} + {2'b00, row, 6'h00} + {8'h00, col};
  endfunction
endpackage

// File: rtl/vga_scanout_fb_ram.sv
// Simple dual-port 76800x3 framebuffer; registered read, old data on a
// same-address read/write collision.
module fb_ram
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [COLOUR_W-1:0] wdata,
  input  logic                ren,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [COLOUR_W-1:0] rdata
);
  logic [COLOUR_W-1:0] mem [0:FB_DEPTH-1];
  logic [COLOUR_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we)  mem[waddr] <= wdata;
    if (ren) rdata_q    <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/vga_scanout.sv
// Pixel-plot framebuffer with a 640x480@60 VGA scan-out, each stored pixel
// doubled in both directions. Timing is overridable for reduced rasters.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int HVIS  = H_VIS,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VVIS  = V_VIS,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);
  localparam int STAGES = 2;
  localparam logic [9:0] H_LAST  = 10'(HVIS + HFP + HSYNC + HBP - 1);
  localparam logic [9:0] V_LAST  = 10'(VVIS + VFP + VSYNC + VBP - 1);
  localparam logic [9:0] H_VIS_C = 10'(HVIS);
  localparam logic [9:0] V_VIS_C = 10'(VVIS);
  localparam logic [9:0] HS_BEG  = 10'(HVIS + HFP);
  localparam logic [9:0] HS_END  = 10'(HVIS + HFP + HSYNC);
  localparam logic [9:0] VS_BEG  = 10'(VVIS + VFP);
  localparam logic [9:0] VS_END  = 10'(VVIS + VFP + VSYNC);

  logic              pix_en_q, pix_en_d;
  logic [9:0]        h_cnt_q, h_cnt_d;
  logic [9:0]        v_cnt_q, v_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]   hs_pipe_q, hs_pipe_d;
  logic [STAGES:1]   vs_pipe_q, vs_pipe_d;
  rgb_t              rgb_q, rgb_d;

  logic              visible, hs_raw, vs_raw;
  logic [ADDR_W-1:0] rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  fb_wr_t            wr;

  always_comb begin
    visible = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs_raw  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_raw  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    rd_addr = visible ? fb_addr(h_cnt_q[9:1], v_cnt_q[9:1]) : '0;
  end

  always_comb begin
    wr.we   = plot && (x < 9'(FB_W)) && (y < 9'(FB_H));
    wr.addr = fb_addr(x, y);
    wr.data = colour;
  end

  fb_ram u_fb (
    .clk   (clock),
    .we    (wr.we),
    .waddr (wr.addr),
    .wdata (wr.data),
    .ren   (pix_en_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    pix_en_d   = ~pix_en_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    vld_pipe_d = vld_pipe_q;
    hs_pipe_d  = hs_pipe_q;
    vs_pipe_d  = vs_pipe_q;
    rgb_d      = rgb_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // stage 1 sits beside the RAM read data, stage STAGES drives the pins
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], visible};
      hs_pipe_d  = {hs_pipe_q[STAGES-1:1], hs_raw};
      vs_pipe_d  = {vs_pipe_q[STAGES-1:1], vs_raw};
      if (vld_pipe_q[STAGES-1]) begin
        rgb_d.r = {8{rd_data[2]}};
        rgb_d.g = {8{rd_data[1]}};
        rgb_d.b = {8{rd_data[0]}};
      end else begin
        rgb_d = '0;
      end
    end
    // high during the pix_en cycle that holds the (0,0) counter state
    frame_start_d = ~pix_en_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      vld_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      vld_pipe_q    <= vld_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      rgb_q         <= rgb_d;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_pipe_q[STAGES];
  assign vga_vs      = vs_pipe_q[STAGES];
  assign vga_blank_n = vld_pipe_q[STAGES];
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = pix_en_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a vertically shortened raster
// (full 800-clock lines, 14 visible of 18 total lines).
module tb_vga_scanout;
  localparam int HTOT = 800;
  localparam int VTOT = 18;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] x = '0;
  logic [8:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_scanout #(
    .HVIS(640), .HFP(16), .HSYNC(96), .HBP(48),
    .VVIS(14), .VFP(1), .VSYNC(2), .VBP(1)
  ) dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .frame_start(frame_start)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_fs(input int limit, output int fs, output int waited);
    waited = 0;
    while (frame_start !== 1'b1 && waited < limit) begin
      @(negedge clock);
      waited++;
    end
    chk("frame_start_seen", 32'(frame_start), 32'd1);
    fs = cyc;
  endtask

  task automatic plot_px(input int px, input int py, input logic [2:0] c);
    x = 9'(px); y = 9'(py); colour = c; plot = 1'b1;
    @(negedge clock);
    plot = 1'b0;
  endtask

  // pixel (h,v) of the frame whose frame_start was seen at cycle base is on
  // the pins from base+3+2*(v*HTOT+h) for two clocks; offs selects the clock
  task automatic chk_pix(input string tag, input int base, input int h, input int v,
                         input int offs, input logic blank, input logic [23:0] rgb);
    wait_cyc(base + 3 + 2 * (v * HTOT + h) + offs);
    chk(tag, 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'({blank, rgb}));
  endtask

  task automatic wait_level(input int sel, input logic lvl, input int limit);
    int n = 0;
    while (((sel == 0) ? vga_hs : vga_vs) !== lvl && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int f1, f2, f3, f4, w, t0;
    repeat (3) @(negedge clock);
    chk("rst_outputs", 32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}), 32'({3'b110, 24'h0}));
    chk("rst_fs_clk_sync", 32'({frame_start, vga_clk, vga_sync_n}), 32'd0);
    resetn = 1'b1;

    wait_fs(4, f1, w);
    chk("fs_after_release", 32'(w), 32'd1);
    @(negedge clock);
    chk("fs_one_clock", 32'(frame_start), 32'd0);
    chk("vga_clk_toggle", 32'(vga_clk), 32'd0);

    for (int py = 0; py < 7; py++)
      for (int px = 0; px < 320; px++)
        plot_px(px, py, 3'b000);
    plot_px(0, 0, 3'b100);
    plot_px(1, 0, 3'b001);
    plot_px(319, 6, 3'b011);
    plot_px(100, 2, 3'b001);
    plot_px(320, 5, 3'b111);
    plot_px(10, 240, 3'b111);

    wait_level(0, 1'b1, 2000);
    wait_level(0, 1'b0, 2000);
    t0 = cyc;
    wait_level(0, 1'b1, 2000);
    chk("hs_low_clocks", 32'(cyc - t0), 32'd192);
    wait_level(0, 1'b0, 2000);
    chk("line_period", 32'(cyc - t0), 32'd1600);

    wait_level(1, 1'b0, 40000);
    t0 = cyc;
    wait_level(1, 1'b1, 10000);
    chk("vs_low_clocks", 32'(cyc - t0), 32'd3200);

    wait_fs(30000, f2, w);
    chk("frame_period", 32'(f2 - f1), 32'(VTOT * HTOT * 2));

    wait_cyc(f2 + 2);
    chk("pre_visible_blank", 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'd0);
    chk_pix("p00_first", f2, 0, 0, 0, 1'b1, 24'hFF0000);
    chk_pix("p10_hold",  f2, 1, 0, 1, 1'b1, 24'hFF0000);
    chk_pix("p20_next",  f2, 2, 0, 0, 1'b1, 24'h0000FF);
    chk_pix("p40_clear", f2, 4, 0, 0, 1'b1, 24'h000000);
    chk_pix("p01_first", f2, 0, 1, 0, 1'b1, 24'hFF0000);
    chk_pix("p11_hold",  f2, 1, 1, 1, 1'b1, 24'hFF0000);
    chk_pix("p21_next",  f2, 2, 1, 0, 1'b1, 24'h0000FF);

    // write lands on the same edge that reads FB(100,2) for raster (200,4)
    wait_cyc(f2 + 2 * (4 * HTOT + 200));
    x = 9'd100; y = 9'd2; colour = 3'b010; plot = 1'b1;
    @(negedge clock);
    plot = 1'b0;
    chk_pix("collision_old", f2, 200, 4, 0, 1'b1, 24'h0000FF);

    chk_pix("oor_addr1600",  f2, 0, 10, 0, 1'b1, 24'h000000);
    chk_pix("oor_x_alias",   f2, 0, 12, 0, 1'b1, 24'h000000);
    chk_pix("edge_637",      f2, 637, 12, 0, 1'b1, 24'h000000);
    chk_pix("edge_638",      f2, 638, 12, 0, 1'b1, 24'h00FFFF);
    chk_pix("edge_639",      f2, 639, 13, 1, 1'b1, 24'h00FFFF);
    chk_pix("edge_blank",    f2, 640, 13, 0, 1'b0, 24'h000000);

    wait_fs(30000, f3, w);
    chk("frame_period_2", 32'(f3 - f2), 32'(VTOT * HTOT * 2));
    chk_pix("collision_new", f3, 200, 4, 0, 1'b1, 24'h00FF00);

    wait_cyc(f3 + 2 * (5 * HTOT + 300));
    chk("pre_reset_blank", 32'(vga_blank_n), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_outputs", 32'({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}), 32'({3'b110, 24'h0}));
    chk("midrst_fs_clk", 32'({frame_start, vga_clk}), 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    wait_fs(4, f4, w);
    chk("midrst_fs_latency", 32'(w), 32'd1);
    chk_pix("midrst_p00", f4, 0, 0, 0, 1'b1, 24'hFF0000);
    chk_pix("midrst_p20", f4, 2, 0, 0, 1'b1, 24'h0000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
